pattern_gen: RTL and testbench

Parametrised sequential test-pattern generator for the PRAM/SRAM data-bus test. It supports any data width and eight pattern modes: walking 1s and walking 0s in both directions, checkerboard, Galois LFSR, incrementing count, and a combined walk sequence. Patterns are produced one word per step under a start/step handshake. It sits between the test sequencer, which issues start and step, and the memory write/compare datapath, which consumes data/valid/last.

---
 rtl/pattern_gen_if.sv | 27 ++
 rtl/pattern_gen.sv | 201 ++++++++++++++++++++
 tb/tb_pattern_gen.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_gen_if.sv
// pattern_gen_if: sequencer <-> pattern generator bundle.
// master drives start/step, slave returns the pattern word.
interface pattern_gen_if #(
    parameter int WIDTH   = 16,
    parameter int INDEX_W = 8
);
    logic               start;
    logic [2:0]         mode;
    logic [WIDTH-1:0]   seed;
    logic               step;
    logic [WIDTH-1:0]   data;
    logic               valid;
    logic [INDEX_W-1:0] index;
    logic               last;
    logic               busy;
    logic               done;

    modport master (
        output start, mode, seed, step,
        input  data, valid, index, last, busy, done
    );

    modport slave (
        input  start, mode, seed, step,
        output data, valid, index, last, busy, done
    );
endinterface

// File: rtl/pattern_gen.sv
// pattern_gen: data-bus test pattern generator (walks,
// checkerboard, LFSR, count) stepped one word at a time.
module pattern_gen #(
    parameter int               WIDTH     = 16,
    parameter int               INDEX_W   = 8,
    parameter int               SEQ_LEN   = 64,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 16'hB400
) (
    input logic           clk,
    input logic           reset,
    pattern_gen_if.slave  bus
);

    localparam int POS_W = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Checkerboard word 0: MSB set, alternating downwards.
    function automatic logic [WIDTH-1:0] checker_word();
        logic [WIDTH-1:0] w;
        w = '0;
        for (int k = 0; k < WIDTH; k++) begin
            w[k] = ((WIDTH - 1 - k) % 2) == 0;
        end
        return w;
    endfunction

    localparam logic [WIDTH-1:0] CHECKER = checker_word();

    // seg[1]: walk left (bit = pos), else right.
    // seg[0]: walking zero (inverted word).
    function automatic logic [WIDTH-1:0] walk_word(
        input logic [1:0]       seg,
        input logic [POS_W-1:0] pos
    );
        logic [WIDTH-1:0] w;
        if (seg[1]) begin
            w = ONE << pos;
        end else begin
            w = ONE << (POS_W'(WIDTH - 1) - pos);
        end
        return seg[0] ? ~w : w;
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_next(
        input logic [WIDTH-1:0] d
    );
        return (d >> 1) ^ (d[0] ? LFSR_TAPS : '0);
    endfunction

    // Word 0 of a freshly started sequence.
    function automatic logic [WIDTH-1:0] first_word(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] s
    );
        logic [WIDTH-1:0] w;
        unique case (m)
            3'd0, 3'd1,
            3'd2, 3'd3: w = walk_word(m[1:0], '0);
            3'd4:       w = CHECKER;
            3'd5:       w = (s == '0) ? ONE : s;
            3'd6:       w = s;
            3'd7:       w = walk_word(2'd0, '0);
            default:    w = '0;
        endcase
        return w;
    endfunction

    // Index of the final word for a given mode.
    function automatic logic [INDEX_W-1:0] last_index(
        input logic [2:0] m
    );
        logic [INDEX_W-1:0] l;
        unique case (m)
            3'd0, 3'd1,
            3'd2, 3'd3: l = INDEX_W'(WIDTH - 1);
            3'd4:       l = INDEX_W'(1);
            3'd5, 3'd6: l = INDEX_W'(SEQ_LEN - 1);
            3'd7:       l = INDEX_W'(4 * WIDTH - 1);
            default:    l = '0;
        endcase
        return l;
    endfunction

    state_t             state_q, state_d;
    logic [2:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   seed_q, seed_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic               valid_q, valid_d;
    logic [1:0]         seg_q, seg_d;
    logic [POS_W-1:0]   pos_q, pos_d;

    logic [INDEX_W-1:0] idx_n;
    logic [1:0]         seg_n;
    logic [POS_W-1:0]   pos_n;
    logic               last_w;

    assign last_w = valid_q && (index_q == last_index(mode_q));

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= '0;
            seed_q  <= '0;
            data_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            seg_q   <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
            data_q  <= data_d;
            index_q <= index_d;
            valid_q <= valid_d;
            seg_q   <= seg_d;
            pos_q   <= pos_d;
        end
    end

    // Next-state logic and next pattern word.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        seed_d  = seed_q;
        data_d  = data_q;
        index_d = index_q;
        valid_d = valid_q;
        seg_d   = seg_q;
        pos_d   = pos_q;

        idx_n = index_q + 1'b1;
        pos_n = pos_q + 1'b1;
        seg_n = seg_q;
        if (mode_q == 3'd7 && pos_q == POS_W'(WIDTH - 1)) begin
            pos_n = '0;
            seg_n = seg_q + 2'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    mode_d  = bus.mode;
                    seed_d  = bus.seed;
                    data_d  = first_word(bus.mode, bus.seed);
                    index_d = '0;
                    valid_d = 1'b1;
                    pos_d   = '0;
                    seg_d   = (bus.mode == 3'd7) ? 2'd0
                                                 : bus.mode[1:0];
                end
            end
            RUN: begin
                if (bus.step) begin
                    if (last_w) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        index_d = '0;
                        data_d  = '0;
                        pos_d   = '0;
                        seg_d   = '0;
                    end else begin
                        index_d = idx_n;
                        pos_d   = pos_n;
                        seg_d   = seg_n;
                        unique case (mode_q)
                            3'd4:    data_d = ~data_q;
                            3'd5:    data_d = lfsr_next(data_q);
                            3'd6:    data_d = seed_q + WIDTH'(idx_n);
                            default: data_d = walk_word(seg_n, pos_n);
                        endcase
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.index = index_q;
    assign bus.last  = last_w;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: directed stimulus with a per-cycle
// behavioural model and literal spot checks.
module tb_pattern_gen;

    localparam logic [15:0] TAPS = 16'hB400;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [15:0] cap [0:255];

    int          ms;
    logic [2:0]  mm;
    logic [15:0] msd;
    int          mi;

    pattern_gen_if #(.WIDTH(16), .INDEX_W(8)) bus ();

    pattern_gen #(
        .WIDTH    (16),
        .INDEX_W  (8),
        .SEQ_LEN  (64),
        .LFSR_TAPS(TAPS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    function automatic int exp_len(input logic [2:0] m);
        case (m)
            3'd4:       return 2;
            3'd5, 3'd6: return 64;
            3'd7:       return 64;
            default:    return 16;
        endcase
    endfunction

    // Word i of mode m computed straight from the rules.
    function automatic logic [15:0] exp_word(
        input logic [2:0]  m,
        input logic [15:0] s,
        input int          i
    );
        logic [15:0] d;
        logic [15:0] ck;
        logic [2:0]  sm;
        int          p;
        for (int k = 0; k < 16; k++) ck[k] = ((15 - k) % 2) == 0;
        sm = m;
        p  = i;
        if (m == 3'd7) begin
            sm = 3'(i / 16);
            p  = i % 16;
        end
        case (sm)
            3'd0: d = 16'h1 << (15 - p);
            3'd1: d = ~(16'h1 << (15 - p));
            3'd2: d = 16'h1 << p;
            3'd3: d = ~(16'h1 << p);
            3'd4: d = (p == 0) ? ck : ~ck;
            3'd5: begin
                d = (s == 16'h0) ? 16'h1 : s;
                for (int n = 0; n < p; n++)
                    d = (d >> 1) ^ (d[0] ? TAPS : 16'h0);
            end
            default: d = s + 16'(p);
        endcase
        return d;
    endfunction

    // Sequence-level model: 0 idle, 1 run, 2 done.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ms  <= 0;
            mm  <= 3'd0;
            msd <= 16'h0;
            mi  <= 0;
        end else begin
            case (ms)
                0: if (bus.start) begin
                    ms  <= 1;
                    mm  <= bus.mode;
                    msd <= bus.seed;
                    mi  <= 0;
                end
                1: if (bus.step) begin
                    if (mi == exp_len(mm) - 1) begin
                        ms <= 2;
                        mi <= 0;
                    end else begin
                        mi <= mi + 1;
                    end
                end
                default: ms <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic        ev;
        logic [15:0] ed;
        ev = (ms == 1);
        ed = ev ? exp_word(mm, msd, mi) : 16'h0;
        cmp("valid", 32'(bus.valid), 32'(ev));
        cmp("data",  32'(bus.data),  32'(ed));
        cmp("index", 32'(bus.index), 32'(mi));
        cmp("last",  32'(bus.last),
            32'(ev && (mi == exp_len(mm) - 1)));
        cmp("busy",  32'(bus.busy),  32'(ms != 0));
        cmp("done",  32'(bus.done),  32'(ms == 2));
        if (bus.valid) cap[bus.index] = bus.data;
    end

    task automatic run_seq(input logic [2:0] m,
                           input logic [15:0] s,
                           input int budget);
        bit got;
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.seed  = s;
        @(negedge clk);
        bus.start = 1'b0;
        bus.step  = 1'b1;
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
        end
        bus.step = 1'b0;
        cmp("done_seen", 32'(got), 32'd1);
        @(negedge clk);
        cmp("done_1cyc", 32'(bus.done), 32'd0);
        cmp("busy_drop", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        bus.start = 1'b0;
        bus.mode  = 3'd0;
        bus.seed  = 16'h0;
        bus.step  = 1'b0;
        reset     = 1'b0;
        #1 reset  = 1'b1;
        repeat (3) @(negedge clk);
        cmp("rst_valid", 32'(bus.valid), 32'd0);
        cmp("rst_data",  32'(bus.data),  32'd0);
        cmp("rst_busy",  32'(bus.busy),  32'd0);
        #2 reset = 1'b0;

        run_seq(3'd0, 16'h0, 40);
        cmp("m0_w0",  32'(cap[0]),  32'h8000);
        cmp("m0_w1",  32'(cap[1]),  32'h4000);
        cmp("m0_w15", 32'(cap[15]), 32'h0001);

        run_seq(3'd7, 16'h0, 100);
        cmp("m7_00", 32'(cap[8'h00]), 32'h8000);
        cmp("m7_10", 32'(cap[8'h10]), 32'h7FFF);
        cmp("m7_1f", 32'(cap[8'h1F]), 32'hFFFE);
        cmp("m7_20", 32'(cap[8'h20]), 32'h0001);
        cmp("m7_3f", 32'(cap[8'h3F]), 32'h7FFF);

        run_seq(3'd5, 16'h0001, 100);
        cmp("lfsr_0", 32'(cap[0]), 32'h0001);
        cmp("lfsr_1", 32'(cap[1]), 32'hB400);
        cmp("lfsr_2", 32'(cap[2]), 32'h5A00);
        cmp("lfsr_3", 32'(cap[3]), 32'h2D00);

        run_seq(3'd5, 16'h0000, 100);
        cmp("lfsr_z0", 32'(cap[0]), 32'h0001);

        run_seq(3'd6, 16'hFFFE, 100);
        cmp("cnt_0", 32'(cap[0]), 32'hFFFE);
        cmp("cnt_1", 32'(cap[1]), 32'hFFFF);
        cmp("cnt_2", 32'(cap[2]), 32'h0000);
        cmp("cnt_3", 32'(cap[3]), 32'h0001);

        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 3'd4;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cmp("hold_data", 32'(bus.data),  32'hAAAA);
            cmp("hold_idx",  32'(bus.index), 32'd0);
            cmp("hold_last", 32'(bus.last),  32'd0);
        end
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        cmp("ckb_1",    32'(bus.data), 32'h5555);
        cmp("ckb_last", 32'(bus.last), 32'd1);
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        cmp("ckb_done", 32'(bus.done), 32'd1);
        @(negedge clk);

        bus.start = 1'b1;
        bus.mode  = 3'd2;
        @(negedge clk);
        bus.start = 1'b0;
        bus.step  = 1'b1;
        repeat (2) @(negedge clk);
        bus.step  = 1'b0;
        bus.start = 1'b1;
        bus.mode  = 3'd5;
        @(negedge clk);
        bus.start = 1'b0;
        cmp("ign_data", 32'(bus.data),  32'h0004);
        cmp("ign_idx",  32'(bus.index), 32'd2);
        bus.step = 1'b1;
        repeat (5) @(negedge clk);
        bus.step = 1'b0;
        cmp("m2_idx7",  32'(bus.index), 32'd7);
        cmp("m2_data7", 32'(bus.data),  32'h0080);
        #2 reset = 1'b1;
        #1;
        cmp("ar_data",  32'(bus.data),  32'd0);
        cmp("ar_valid", 32'(bus.valid), 32'd0);
        cmp("ar_index", 32'(bus.index), 32'd0);
        cmp("ar_last",  32'(bus.last),  32'd0);
        cmp("ar_busy",  32'(bus.busy),  32'd0);
        cmp("ar_done",  32'(bus.done),  32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        cmp("ar_nodone", 32'(bus.done), 32'd0);

        run_seq(3'd3, 16'h0, 40);
        cmp("m3_w0", 32'(cap[0]), 32'hFFFE);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
